// File: rtl/hmj_ld_pkg.sv
// Shared types and constants for the rangefinder distance-to-BCD path.
package hmj_ld_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } hmj_state_e;

    localparam int DIN_W_DEF  = 16;
    localparam int DIGITS_DEF = 5;

    localparam logic [3:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/hmj_dab_digit.sv
// Per-nibble shift-and-add-3 correction: a digit of 5 or more gets +3 before the next shift.
module hmj_dab_digit (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/hmj_dist_bcd.sv
// Sequential binary-to-BCD converter with one-deep pending buffer, drop pulse and stale-link flag.
// Define HMJ_LD_LZB_EN to blank leading zeros in the two top digits of o_bcd.
module hmj_dist_bcd
    import hmj_ld_pkg::*;
#(
    parameter int DIN_W        = DIN_W_DEF,
    parameter int DIGITS       = DIGITS_DEF,
    parameter int STALE_CYCLES = 50_000_000
) (
    input  logic                  i_sys_clk,
    input  logic                  i_reset,
    input  logic                  i_dist_vld,
    input  logic [DIN_W-1:0]      i_dist,
    output logic [DIGITS*4-1:0]   o_bcd,
    output logic                  o_bcd_vld,
    output logic                  o_busy,
    output logic                  o_drop,
    output logic                  o_stale
);

    localparam int BCD_W = DIGITS * 4;
    localparam int SR_W  = BCD_W + DIN_W;
    localparam int CNT_W = $clog2(DIN_W + 1);
    localparam int STL_W = $clog2(STALE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIN_W - 1);
    localparam logic [STL_W-1:0] STL_MAX  = STL_W'(STALE_CYCLES);

    hmj_state_e         r_state;
    hmj_state_e         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [SR_W-1:0]    r_sr;
    logic [DIN_W-1:0]   r_pend;
    logic               r_pend_vld;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_bcd_vld;
    logic               r_drop;
    logic [STL_W-1:0]   r_stale_cnt;

    logic               w_load;
    logic               w_load_pend;
    logic               w_pend_wr;
    logic               w_drop;
    logic [BCD_W-1:0]   w_corr;
    logic [SR_W-1:0]    w_sr_shift;
    logic [BCD_W-1:0]   w_bcd_field;
    logic [BCD_W-1:0]   w_bcd_fmt;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            hmj_dab_digit u_dig (
                .i_nib (r_sr[DIN_W + 4*g +: 4]),
                .o_nib (w_corr[4*g +: 4])
            );
        end
    endgenerate

    // Correct every digit first, then shift the whole register one place.
    assign w_sr_shift  = {w_corr, r_sr[DIN_W-1:0]} << 1;
    assign w_bcd_field = r_sr[SR_W-1:DIN_W];

`ifdef HMJ_LD_LZB_EN
    function automatic logic [BCD_W-1:0] f_blank(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        if (v[BCD_W-1 -: 4] == 4'd0) begin
            r[BCD_W-1 -: 4] = BCD_BLANK;
            if (v[BCD_W-5 -: 4] == 4'd0)
                r[BCD_W-5 -: 4] = BCD_BLANK;
        end
        return r;
    endfunction

    assign w_bcd_fmt = f_blank(w_bcd_field);
`else
    assign w_bcd_fmt = w_bcd_field;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_pend = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_dist_vld) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_LAST)
                    w_state_nxt = DONE;
            end
            DONE: begin
                if (r_pend_vld) begin
                    w_load      = 1'b1;
                    w_load_pend = 1'b1;
                    w_state_nxt = SHIFT;
                end else if (i_dist_vld) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A sample arriving in DONE with a full buffer replaces a word consumed that same cycle.
    assign w_pend_wr = i_dist_vld && ((r_state == SHIFT) || (r_state == DONE && r_pend_vld));
    assign w_drop    = i_dist_vld && (r_state == SHIFT) && r_pend_vld;

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_pend_vld <= 1'b0;
            r_bcd      <= '0;
            r_bcd_vld  <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            if (w_load)
                r_cnt <= '0;
            else if (r_state == SHIFT)
                r_cnt <= r_cnt + CNT_W'(1);

            if (w_pend_wr)
                r_pend_vld <= 1'b1;
            else if (r_state == DONE)
                r_pend_vld <= 1'b0;

            r_bcd_vld <= (r_state == DONE);
            if (r_state == DONE)
                r_bcd <= w_bcd_fmt;

            r_drop <= w_drop;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (w_load)
            r_sr <= {{BCD_W{1'b0}}, (w_load_pend ? r_pend : i_dist)};
        else if (r_state == SHIFT)
            r_sr <= w_sr_shift;

        if (w_pend_wr)
            r_pend <= i_dist;
    end

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset)
            r_stale_cnt <= '0;
        else if (i_dist_vld)
            r_stale_cnt <= '0;
        else if (r_stale_cnt != STL_MAX)
            r_stale_cnt <= r_stale_cnt + STL_W'(1);
    end

    assign o_bcd     = r_bcd;
    assign o_bcd_vld = r_bcd_vld;
    assign o_busy    = (r_state != IDLE);
    assign o_drop    = r_drop;
    assign o_stale   = (r_stale_cnt == STL_MAX);

endmodule
